frame_dump: RTL and testbench
=============================

Name: frame_dump

Overview:
- Synthesizable, parametrised frame-capture engine for the BottleFlip display path.
- On each render tick it snapshots the current frame from the renderer's second read port, together with score and perfect.
- It serialises everything as an ASCII byte stream over a valid/ready interface, one line per frame, for a UART or logger.
- It generalises the simulation-only frame dump to any resolution, pixel depth and memory read latency, and adds back-pressure, prefetch and overrun accounting.

Parameters:
- PX_WIDTH, 64, pixels per row
- PX_HEIGHT, 48, rows per frame
- PIX_BITS, 3, bits per pixel colour code (1..4)
- ADDR_W, 16, read address width; must satisfy PX_WIDTH*PX_HEIGHT <= 2**ADDR_W
- MEM_LAT, 1, cycles from rd_addr to valid rd_data (1..3)
- FIFO_DEPTH, 4, prefetch FIFO entries; must be >= MEM_LAT+1

Ports:
- clk  in  1  system clock
- clr  in  1  asynchronous active-high reset
- frame_tick  in  1  single-cycle pulse requesting a frame capture
- score  in  16  four BCD digits, [15:12] most significant
- perfect  in  1  perfect-landing flag
- rd_addr  out  ADDR_W  pixel read address to renderer second port
- rd_data  in  PIX_BITS  pixel code, valid MEM_LAT cycles after rd_addr
- out_data  out  8  ASCII byte
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts byte when out_valid & out_ready
- busy  out  1  capture in progress
- frame_cnt  out  16  completed frames, wraps at 65535->0
- overrun_cnt  out  8  ignored ticks, saturates at 255

Behaviour:
- Reset (clr async, active-high): state IDLE, rd_addr=0, out_valid=0, out_data=0, busy=0, frame_cnt=0, overrun_cnt=0, FIFO empty, in-flight count 0.
- IDLE:
  - On frame_tick: latch score and perfect into snapshot registers, clear row/col counters, set busy, go to PIXELS.
  - frame_tick while busy (any other state) is ignored and overrun_cnt increments, saturating at 255.
- PIXELS:
  - Issue one read per cycle while (FIFO occupancy + in-flight reads) < FIFO_DEPTH.
  - rd_addr advances by an incremental counter (col wraps at PX_WIDTH-1, row increments); no multiplier.
  - Last issued address is PX_WIDTH*PX_HEIGHT-1. Once it is issued, stop issuing and go to DRAIN.
  - Returning data is pushed into the FIFO exactly MEM_LAT cycles after issue, using a shift-register valid pipe.
- Output of pixels:
  - FIFO head drives out_data = 8'h30 + zero-extended code; out_valid = FIFO non-empty.
  - Pop on handshake.
  - Full throughput (one byte per cycle) with out_ready held high.
- DRAIN: wait until in-flight = 0 and FIFO empty, then go to TRAILER.
- TRAILER: emit 8 bytes in order: 0x20, digit3, digit2, digit1, digit0 (each 8'h30+nibble, no range check), 0x20, 8'h30+perfect, 0x0A.
  - Each byte is held until accepted.
  - After the 0x0A handshake: frame_cnt+1, busy=0, go to IDLE.
- AXI-style rule: once out_valid=1, out_data is stable until handshake; out_valid never drops without a handshake.
- Snapshot score/perfect are used in the trailer, never the live inputs.
- frame_tick coincident with the final trailer handshake counts as an overrun (busy still 1 that cycle).
- Reset mid-frame aborts immediately; no partial trailer is emitted.

Optional Feature:
- Macro FRAME_DUMP_ROW_NL_EN.
- When defined: after the last pixel of each row except the final row, insert one 0x0A byte into the stream (pushed through the FIFO as a marker entry).
  - Bytes per frame = W*H + (H-1) + 8.
- When undefined: bytes per frame = W*H + 8; no row markers.

Decomposition:
- Shared package frame_dump_pkg holds:
  - the state encoding (IDLE, PIXELS, DRAIN, TRAILER)
  - ASCII constants (CH_ZERO=8'h30, CH_SP=8'h20, CH_NL=8'h0A)
  - TRAILER_LEN=8
- One sub-module: dump_fifo, a synchronous FIFO with parameters width and depth.
  - Outputs: full, empty and occupancy.
  - Simultaneous push/pop allowed when full or empty.

Test Plan:
- Frame content: W=4, H=2, MEM_LAT=1, memory holds code = addr%8, score=16'h0123, perfect=1, out_ready=1.
  - Required stream: "01234567" then " 0123 1\n"; frame_cnt=1; total 16 bytes in 16 consecutive cycles after the first valid.
- Back-pressure: same setup, out_ready toggling 1010… or random 30%.
  - Byte sequence identical; no byte duplicated or dropped; out_data stable while stalled.
- Latency: MEM_LAT=3, FIFO_DEPTH=4.
  - Correct order; never more than 4 outstanding; full rate with out_ready=1.
- Overrun: three frame_ticks during one capture.
  - overrun_cnt=3, frame_cnt=1; score changed mid-frame does not alter the trailer.
- Reset mid-frame: assert clr after byte 5.
  - All outputs return to reset values immediately; the next tick produces a complete, correct frame.
- FRAME_DUMP_ROW_NL_EN: W=4, H=2 yields "0123\n4567 0123 1\n" (17 bytes).

Source files
------------

// File: rtl/frame_dump_pkg.sv
// Shared definitions for the frame_dump capture engine: FSM encoding,
// ASCII constants and the trailer byte formatter.
package frame_dump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PIXELS,
    ST_DRAIN,
    ST_TRAILER
  } state_e;

  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_SP   = 8'h20;
  localparam logic [7:0] CH_NL   = 8'h0A;

  localparam int unsigned TRAILER_LEN = 8;

  // Trailer layout: " dddd p\n", digits are raw nibbles offset by '0'
  function automatic logic [7:0] trailer_byte(input logic [2:0]  idx,
                                              input logic [15:0] sc,
                                              input logic        pf);
    logic [7:0] b;
    b = CH_NL;
    case (idx)
      3'd0, 3'd5: b = CH_SP;
      3'd1:       b = CH_ZERO + 8'(sc[15:12]);
      3'd2:       b = CH_ZERO + 8'(sc[11:8]);
      3'd3:       b = CH_ZERO + 8'(sc[7:4]);
      3'd4:       b = CH_ZERO + 8'(sc[3:0]);
      3'd6:       b = CH_ZERO + 8'(pf);
      default:    b = CH_NL;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/frame_dump_fifo.sv
// dump_fifo: synchronous prefetch FIFO with occupancy; push is accepted
// while full when a pop happens in the same cycle.
module dump_fifo #(
  parameter  int unsigned WIDTH = 4,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_inc(wr_q);
      if (do_pop)  rd_q <= ptr_inc(rd_q);
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: it is only read behind a non-zero count
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/frame_dump.sv
// frame_dump: snapshots a frame via the renderer read port and streams it as
// ASCII over valid/ready. Define FRAME_DUMP_ROW_NL_EN to insert row newlines.
module frame_dump
  import frame_dump_pkg::*;
#(
  parameter int unsigned PX_WIDTH   = 64,
  parameter int unsigned PX_HEIGHT  = 48,
  parameter int unsigned PIX_BITS   = 3,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                frame_tick,
  input  logic [15:0]         score,
  input  logic                perfect,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [PIX_BITS-1:0] rd_data,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic [15:0]         frame_cnt,
  output logic [7:0]          overrun_cnt
);

  localparam int unsigned COL_W = (PX_WIDTH > 1) ? $clog2(PX_WIDTH) : 1;
  localparam int unsigned ROW_W = (PX_HEIGHT > 1) ? $clog2(PX_HEIGHT) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned ENT_W = PIX_BITS + 1;
  localparam int unsigned TR_W  = 4;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [15:0]         snap_score_q, snap_score_d;
  logic                snap_perf_q, snap_perf_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic [TR_W-1:0]     tr_idx_q, tr_idx_d;
  logic [7:0]          out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [7:0]          overrun_q, overrun_d;
  logic [MEM_LAT-1:0]  vpipe_q, mpipe_q;
`ifdef FRAME_DUMP_ROW_NL_EN
  logic                nl_pend_q, nl_pend_d;
`endif

  logic                issue_c, issue_mk_c, load_c, hs_c, pop_c, push_c, credit_c;
  logic [ENT_W-1:0]    push_data_c, fifo_head;
  logic                fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [SUM_W-1:0]    outstanding_c;

  // Marker entries carry no pixel; their code field is forced to zero
  assign push_c      = vpipe_q[MEM_LAT-1];
  assign push_data_c = {mpipe_q[MEM_LAT-1],
                        mpipe_q[MEM_LAT-1] ? {PIX_BITS{1'b0}} : rd_data};

  dump_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .clr     (clr),
    .push_i  (push_c),
    .data_i  (push_data_c),
    .pop_i   (pop_c),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    col_d        = col_q;
    row_d        = row_q;
    snap_score_d = snap_score_q;
    snap_perf_d  = snap_perf_q;
    tr_idx_d     = tr_idx_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    busy_d       = busy_q;
    frame_cnt_d  = frame_cnt_q;
    overrun_d    = overrun_q;
`ifdef FRAME_DUMP_ROW_NL_EN
    nl_pend_d    = nl_pend_q;
`endif
    issue_c      = 1'b0;
    issue_mk_c   = 1'b0;

    load_c = !out_valid_q || out_ready;
    hs_c   = out_valid_q && out_ready;
    pop_c  = !fifo_empty && load_c;

    // Credit counts this cycle's pop so MEM_LAT+1 <= FIFO_DEPTH sustains full rate
    outstanding_c = SUM_W'(fifo_count) + SUM_W'(inflight_q) - SUM_W'(pop_c);
    credit_c      = (outstanding_c < SUM_W'(FIFO_DEPTH)) && !fifo_full;

    if (hs_c) out_valid_d = 1'b0;
    if (pop_c) begin
      out_valid_d = 1'b1;
      out_data_d  = fifo_head[PIX_BITS] ? CH_NL
                                        : CH_ZERO + 8'(fifo_head[PIX_BITS-1:0]);
    end

    if (frame_tick && (state_q != ST_IDLE) && (overrun_q != 8'hFF))
      overrun_d = overrun_q + 8'd1;

    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          snap_score_d = score;
          snap_perf_d  = perfect;
          addr_d       = '0;
          col_d        = '0;
          row_d        = '0;
          busy_d       = 1'b1;
`ifdef FRAME_DUMP_ROW_NL_EN
          nl_pend_d    = 1'b0;
`endif
          state_d      = ST_PIXELS;
        end
      end
      ST_PIXELS: begin
        if (credit_c) begin
          issue_c = 1'b1;
`ifdef FRAME_DUMP_ROW_NL_EN
          if (nl_pend_q) begin
            issue_mk_c = 1'b1;
            nl_pend_d  = 1'b0;
          end else
`endif
          begin
            if (col_q == COL_W'(PX_WIDTH - 1)) begin
              col_d = '0;
              if (row_q == ROW_W'(PX_HEIGHT - 1)) begin
                state_d = ST_DRAIN;
              end else begin
                row_d  = row_q + ROW_W'(1);
                addr_d = addr_q + ADDR_W'(1);
`ifdef FRAME_DUMP_ROW_NL_EN
                nl_pend_d = 1'b1;
`endif
              end
            end else begin
              col_d  = col_q + COL_W'(1);
              addr_d = addr_q + ADDR_W'(1);
            end
          end
        end
      end
      ST_DRAIN: begin
        // Leave as the last FIFO entry pops so the trailer follows without a bubble
        if ((inflight_q == '0) && (fifo_count == CNT_W'(pop_c))) begin
          tr_idx_d = '0;
          state_d  = ST_TRAILER;
        end
      end
      ST_TRAILER: begin
        if (tr_idx_q == TR_W'(TRAILER_LEN)) begin
          if (hs_c) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
          end
        end else if (load_c) begin
          out_valid_d = 1'b1;
          out_data_d  = trailer_byte(tr_idx_q[2:0], snap_score_q, snap_perf_q);
          tr_idx_d    = tr_idx_q + TR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    inflight_d = inflight_q + CNT_W'(issue_c) - CNT_W'(push_c);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      snap_score_q <= '0;
      snap_perf_q  <= 1'b0;
      inflight_q   <= '0;
      tr_idx_q     <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_cnt_q  <= '0;
      overrun_q    <= '0;
      vpipe_q      <= '0;
      mpipe_q      <= '0;
`ifdef FRAME_DUMP_ROW_NL_EN
      nl_pend_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      col_q        <= col_d;
      row_q        <= row_d;
      snap_score_q <= snap_score_d;
      snap_perf_q  <= snap_perf_d;
      inflight_q   <= inflight_d;
      tr_idx_q     <= tr_idx_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      frame_cnt_q  <= frame_cnt_d;
      overrun_q    <= overrun_d;
      vpipe_q[0]   <= issue_c;
      mpipe_q[0]   <= issue_mk_c;
      for (int k = 1; k < int'(MEM_LAT); k++) begin
        vpipe_q[k] <= vpipe_q[k-1];
        mpipe_q[k] <= mpipe_q[k-1];
      end
`ifdef FRAME_DUMP_ROW_NL_EN
      nl_pend_q    <= nl_pend_d;
`endif
    end
  end

  assign rd_addr     = addr_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign frame_cnt   = frame_cnt_q;
  assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_frame_dump.sv
// Bench for frame_dump: a 4x2 frame on two instances (read latency 1 and 3)
// checked byte-for-byte against hand-written ASCII streams.
module tb_frame_dump;

  localparam int unsigned AW = 16;

  logic          clk, clr, frame_tick, perfect, out_ready;
  logic [15:0]   score;
  logic [AW-1:0] ra [2];
  logic [2:0]    rd [2];
  logic [7:0]    od [2];
  logic          ov [2];
  logic          bz [2];
  logic [15:0]   fc [2];
  logic [7:0]    oc [2];

  frame_dump #(.PX_WIDTH(4), .PX_HEIGHT(2), .PIX_BITS(3), .ADDR_W(AW),
               .MEM_LAT(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .clr(clr), .frame_tick(frame_tick), .score(score),
    .perfect(perfect), .rd_addr(ra[0]), .rd_data(rd[0]), .out_data(od[0]),
    .out_valid(ov[0]), .out_ready(out_ready), .busy(bz[0]),
    .frame_cnt(fc[0]), .overrun_cnt(oc[0]));

  frame_dump #(.PX_WIDTH(4), .PX_HEIGHT(2), .PIX_BITS(3), .ADDR_W(AW),
               .MEM_LAT(3), .FIFO_DEPTH(4)) dut3 (
    .clk(clk), .clr(clr), .frame_tick(frame_tick), .score(score),
    .perfect(perfect), .rd_addr(ra[1]), .rd_data(rd[1]), .out_data(od[1]),
    .out_valid(ov[1]), .out_ready(out_ready), .busy(bz[1]),
    .frame_cnt(fc[1]), .overrun_cnt(oc[1]));

  // Renderer models: code = addr % 8 after 1 and 3 cycles
  logic [2:0] m1, p1, p2, p3;
  always @(posedge clk) begin
    m1 <= ra[0][2:0];
    p1 <= ra[1][2:0];
    p2 <= p1;
    p3 <= p2;
  end
  assign rd[0] = m1;
  assign rd[1] = p3;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef FRAME_DUMP_ROW_NL_EN
  localparam string PIX = "0123\n4567";
`else
  localparam string PIX = "01234567";
`endif

  int n_cmp = 0, n_fail = 0, exp_frames = 0, mode = 0;
  int base0, base1;

  // Ready pattern: 0 always, 1 toggle, 2 random 30% stall, 3 held low
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        2:       out_ready = ($urandom_range(0, 99) >= 30);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Handshake collector and stall-stability monitor
  logic [7:0] rxq0[$], rxq1[$];
  int         st0[$], st1[$];
  int         cyc = 0, stab_err = 0;
  logic       pv0 = 0, pv1 = 0, pr = 0;
  logic [7:0] pd0 = 0, pd1 = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (clr) begin
      pv0 <= 1'b0;
      pv1 <= 1'b0;
    end else begin
      if ((pv0 && !pr && (!ov[0] || od[0] != pd0)) ||
          (pv1 && !pr && (!ov[1] || od[1] != pd1)))
        stab_err <= stab_err + 1;
      if (ov[0] && out_ready) begin rxq0.push_back(od[0]); st0.push_back(cyc); end
      if (ov[1] && out_ready) begin rxq1.push_back(od[1]); st1.push_back(cyc); end
      pv0 <= ov[0]; pd0 <= od[0];
      pv1 <= ov[1]; pd1 <= od[1];
      pr  <= out_ready;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
  endtask

  task automatic start_frame(input logic [15:0] sc, input logic pf);
    base0 = rxq0.size();
    base1 = rxq1.size();
    score = sc;
    perfect = pf;
    tick();
  endtask

  task automatic wait_done(input int len);
    int c;
    c = 0;
    while (c < 4000 && !(rxq0.size() >= base0 + len && rxq1.size() >= base1 + len
                         && !bz[0] && !bz[1])) begin
      @(posedge clk);
      c++;
    end
    #1;
    chk("frame_done_in_time", 32'(c < 4000), 32'd1);
  endtask

  task automatic check_stream(input int k, input string exp, input bit rate);
    int         base, n, len;
    logic [7:0] b;
    base = (k == 0) ? base0 : base1;
    n    = (k == 0) ? rxq0.size() : rxq1.size();
    len  = exp.len();
    chk($sformatf("len_dut%0d", k), 32'(n - base), 32'(len));
    for (int i = 0; i < len; i++) begin
      b = 8'hEE;
      if (base + i < n) b = (k == 0) ? rxq0[base + i] : rxq1[base + i];
      chk($sformatf("byte_dut%0d[%0d]", k, i), 32'(b), 32'(exp[i]));
    end
    if (rate && n >= base + len) begin
      if (k == 0) chk("full_rate_dut0", 32'(st0[base + len - 1] - st0[base]), 32'(len - 1));
      else        chk("full_rate_dut1", 32'(st1[base + len - 1] - st1[base]), 32'(len - 1));
    end
  endtask

  task automatic finish_frame(input string exp, input bit rate);
    wait_done(exp.len());
    exp_frames++;
    for (int k = 0; k < 2; k++) begin
      check_stream(k, exp, rate);
      chk($sformatf("frame_cnt_dut%0d", k), 32'(fc[k]), 32'(exp_frames));
    end
    chk("stall_stability", 32'(stab_err), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_rd_addr%0d", tag, k),   32'(ra[k]), 32'd0);
      chk($sformatf("%s_valid%0d", tag, k),     32'(ov[k]), 32'd0);
      chk($sformatf("%s_data%0d", tag, k),      32'(od[k]), 32'd0);
      chk($sformatf("%s_busy%0d", tag, k),      32'(bz[k]), 32'd0);
      chk($sformatf("%s_frame_cnt%0d", tag, k), 32'(fc[k]), 32'd0);
      chk($sformatf("%s_overrun%0d", tag, k),   32'(oc[k]), 32'd0);
    end
  endtask

  typedef struct {
    logic [15:0] score;
    logic        perfect;
    int          rmode;
    string       trailer;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int c;
    tbl[0] = '{16'h0123, 1'b1, 0, " 0123 1\n"};
    tbl[1] = '{16'h0123, 1'b1, 1, " 0123 1\n"};
    tbl[2] = '{16'h9870, 1'b0, 2, " 9870 0\n"};
    tbl[3] = '{16'hAF09, 1'b1, 0, " :?09 1\n"};

    clr = 1'b1; frame_tick = 1'b0; score = '0; perfect = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    clr = 1'b0;

    for (int v = 0; v < 4; v++) begin
      mode = tbl[v].rmode;
      start_frame(tbl[v].score, tbl[v].perfect);
      finish_frame({PIX, tbl[v].trailer}, tbl[v].rmode == 0);
    end
    mode = 0;
    chk("no_overrun_yet", 32'(oc[0]), 32'd0);

    // Three ticks while busy, plus a live score change the trailer must ignore
    start_frame(16'h4567, 1'b0);
    score = 16'h5555; perfect = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    finish_frame({PIX, " 4567 0\n"}, 1'b1);
    chk("overrun3_dut0", 32'(oc[0]), 32'd3);
    chk("overrun3_dut1", 32'(oc[1]), 32'd3);

    // Tick coincident with the final trailer handshake of the fast instance
    start_frame(16'h1111, 1'b1);
    c = 0;
    while (c < 200 && !(ov[0] && od[0] == 8'h0A && bz[0] &&
                        rxq0.size() - base0 >= PIX.len() + 6)) begin
      @(negedge clk);
      c++;
    end
    chk("found_final_nl", 32'(c < 200), 32'd1);
    frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    finish_frame({PIX, " 1111 1\n"}, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    chk("coincident_overrun", 32'(oc[0]), 32'd4);
    chk("no_restart_busy", 32'(bz[0]), 32'd0);
    chk("no_extra_bytes", 32'(rxq0.size() - base0), 32'(PIX.len() + 8));

    // Saturation while the sink stalls the frame
    mode = 3;
    start_frame(16'h2020, 1'b0);
    @(posedge clk); #1 frame_tick = 1'b1;
    repeat (300) @(posedge clk);
    #1 frame_tick = 1'b0;
    chk("overrun_sat_dut0", 32'(oc[0]), 32'd255);
    chk("overrun_sat_dut1", 32'(oc[1]), 32'd255);
    chk("stalled_busy", 32'(bz[0]), 32'd1);
    mode = 0;
    finish_frame({PIX, " 2020 0\n"}, 1'b0);

    // Reset after the fifth byte, then a clean frame
    start_frame(16'h0987, 1'b1);
    c = 0;
    while (c < 200 && rxq0.size() < base0 + 5) begin
      @(negedge clk);
      c++;
    end
    chk("reached_byte5", 32'(c < 200), 32'd1);
    #1 clr = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); @(posedge clk);
    #1 clr = 1'b0;
    exp_frames = 0;
    start_frame(16'h0123, 1'b1);
    finish_frame({PIX, " 0123 1\n"}, 1'b1);
    chk("post_reset_overrun", 32'(oc[0]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
